// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle controller and its RV32I datapath.
// master: the controller side; slave: the datapath/memory side.
interface multicycle_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             br_taken;
  logic             mem_req;
  logic             mem_we;
  logic             iord;
  logic             ir_we;
  logic             pc_we;
  logic             pc_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             reg_we;
  logic [1:0]       wb_sel;
  logic             illegal;
  logic [WIDTH-1:0] instret;
  logic [3:0]       state;

  modport master (
    input  opcode, mem_ready, br_taken,
    output mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b, alu_op,
           reg_we, wb_sel, illegal, instret, state
  );

  modport slave (
    output opcode, mem_ready, br_taken,
    input  mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b, alu_op,
           reg_we, wb_sel, illegal, instret, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Control FSM for a shared-ALU, shared-memory multi-cycle RV32I datapath.
// Sequences fetch/decode/execute/writeback, owns the retired-instruction
// counter and a sticky illegal-opcode flag.
module multicycle_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StExecI   = 4'd3,
    StMemAddr = 4'd4,
    StMemRd   = 4'd5,
    StMemWr   = 4'd6,
    StWbAlu   = 4'd7,
    StWbMem   = 4'd8,
    StBranch  = 4'd9,
    StJal     = 4'd10,
    StJalr    = 4'd11,
    StLui     = 4'd12,
    StTrap    = 4'd15
  } state_e;

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcI      = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;
  localparam logic [1:0] SrcAZero  = 2'b11;
  localparam logic [1:0] SrcBRs2   = 2'b00;
  localparam logic [1:0] SrcBImm   = 2'b01;
  localparam logic [1:0] SrcBFour  = 2'b10;
  localparam logic [1:0] AluAdd    = 2'b00;
  localparam logic [1:0] AluFunct  = 2'b01;
  localparam logic [1:0] AluBranch = 2'b10;
  localparam logic [1:0] WbAluOut  = 2'b00;
  localparam logic [1:0] WbMdr     = 2'b01;
  localparam logic [1:0] WbPc      = 2'b10;

  state_e           r_state;
  state_e           w_state_next;
  logic             r_illegal;
  logic [WIDTH-1:0] r_instret;
  logic             w_retire;

  logic             w_mem_req;
  logic             w_mem_we;
  logic             w_iord;
  logic             w_ir_we;
  logic             w_pc_we;
  logic             w_pc_src;
  logic [1:0]       w_alu_src_a;
  logic [1:0]       w_alu_src_b;
  logic [1:0]       w_alu_op;
  logic             w_reg_we;
  logic [1:0]       w_wb_sel;

  // State, sticky trap flag and retire counter; all cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StFetch;
      r_illegal <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state <= w_state_next;
      // Flag rises the cycle after TRAP is first occupied.
      if (r_state == StTrap) begin
        r_illegal <= 1'b1;
      end
      if (w_retire) begin
        r_instret <= r_instret + {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  // Next-state decode plus Moore/Mealy datapath controls.
  always_comb begin
    w_state_next = r_state;
    w_retire     = 1'b0;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_iord       = 1'b0;
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_pc_src     = 1'b0;
    w_alu_src_a  = SrcAPc;
    w_alu_src_b  = SrcBRs2;
    w_alu_op     = AluAdd;
    w_reg_we     = 1'b0;
    w_wb_sel     = WbAluOut;

    case (r_state)
      StFetch: begin
        w_mem_req   = 1'b1;
        w_alu_src_a = SrcAPc;
        w_alu_src_b = SrcBFour;
        if (bus.mem_ready) begin
          w_ir_we      = 1'b1;
          w_pc_we      = 1'b1;
          w_state_next = StDecode;
        end
      end
      StDecode: begin
        // Precompute OLDPC + imm so branch/jump/AUIPC find their target in ALUOUT.
        w_alu_src_a = SrcAOldPc;
        w_alu_src_b = SrcBImm;
        case (bus.opcode)
          OpcR:              w_state_next = StExecR;
          OpcI:              w_state_next = StExecI;
          OpcLoad, OpcStore: w_state_next = StMemAddr;
          OpcBranch:         w_state_next = StBranch;
          OpcJal:            w_state_next = StJal;
          OpcJalr:           w_state_next = StJalr;
          OpcLui:            w_state_next = StLui;
          OpcAuipc:          w_state_next = StWbAlu;
          default:           w_state_next = StTrap;
        endcase
      end
      StExecR: begin
        w_alu_src_a  = SrcARs1;
        w_alu_src_b  = SrcBRs2;
        w_alu_op     = AluFunct;
        w_state_next = StWbAlu;
      end
      StExecI: begin
        w_alu_src_a  = SrcARs1;
        w_alu_src_b  = SrcBImm;
        w_alu_op     = AluFunct;
        w_state_next = StWbAlu;
      end
      StMemAddr: begin
        w_alu_src_a  = SrcARs1;
        w_alu_src_b  = SrcBImm;
        w_state_next = (bus.opcode == OpcLoad) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        if (bus.mem_ready) begin
          w_state_next = StWbMem;
        end
      end
      StMemWr: begin
        w_mem_req = 1'b1;
        w_mem_we  = 1'b1;
        w_iord    = 1'b1;
        if (bus.mem_ready) begin
          w_state_next = StFetch;
          w_retire     = 1'b1;
        end
      end
      StWbAlu: begin
        w_reg_we     = 1'b1;
        w_wb_sel     = WbAluOut;
        w_state_next = StFetch;
        w_retire     = 1'b1;
      end
      StWbMem: begin
        w_reg_we     = 1'b1;
        w_wb_sel     = WbMdr;
        w_state_next = StFetch;
        w_retire     = 1'b1;
      end
      StBranch: begin
        w_alu_src_a  = SrcARs1;
        w_alu_src_b  = SrcBRs2;
        w_alu_op     = AluBranch;
        w_pc_src     = 1'b1;
        w_pc_we      = bus.br_taken;
        w_state_next = StFetch;
        w_retire     = 1'b1;
      end
      StJal: begin
        w_reg_we     = 1'b1;
        w_wb_sel     = WbPc;
        w_pc_we      = 1'b1;
        w_pc_src     = 1'b1;
        w_state_next = StFetch;
        w_retire     = 1'b1;
      end
      StJalr: begin
        // Target comes straight off the ALU; the datapath clears bit 0.
        w_alu_src_a  = SrcARs1;
        w_alu_src_b  = SrcBImm;
        w_pc_src     = 1'b0;
        w_pc_we      = 1'b1;
        w_reg_we     = 1'b1;
        w_wb_sel     = WbPc;
        w_state_next = StFetch;
        w_retire     = 1'b1;
      end
      StLui: begin
        w_alu_src_a  = SrcAZero;
        w_alu_src_b  = SrcBImm;
        w_state_next = StWbAlu;
      end
      StTrap: begin
        w_state_next = StTrap;
      end
      default: begin
        // Codes 13/14 are unreachable in normal operation; park them in TRAP.
        w_state_next = StTrap;
      end
    endcase
  end

  // Enables are squashed while reset is high so no write leaks out mid-handshake.
  assign bus.mem_req   = w_mem_req & ~reset;
  assign bus.mem_we    = w_mem_we  & ~reset;
  assign bus.ir_we     = w_ir_we   & ~reset;
  assign bus.pc_we     = w_pc_we   & ~reset;
  assign bus.reg_we    = w_reg_we  & ~reset;
  assign bus.iord      = w_iord;
  assign bus.pc_src    = w_pc_src;
  assign bus.alu_src_a = w_alu_src_a;
  assign bus.alu_src_b = w_alu_src_b;
  assign bus.alu_op    = w_alu_op;
  assign bus.wb_sel    = w_wb_sel;
  assign bus.illegal   = r_illegal;
  assign bus.instret   = r_instret;
  assign bus.state     = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected state
// trajectories built from opcode class and memory wait counts, with the
// expected control word per state taken from the control table.
module tb_multicycle_ctrl;

  // Narrow counter so the random run exercises the instret wrap.
  localparam int unsigned W = 5;

  localparam logic [6:0] OpR  = 7'b0110011;
  localparam logic [6:0] OpI  = 7'b0010011;
  localparam logic [6:0] OpLd = 7'b0000011;
  localparam logic [6:0] OpSt = 7'b0100011;
  localparam logic [6:0] OpBr = 7'b1100011;
  localparam logic [6:0] OpJl = 7'b1101111;
  localparam logic [6:0] OpJr = 7'b1100111;
  localparam logic [6:0] OpLu = 7'b0110111;
  localparam logic [6:0] OpAu = 7'b0010111;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic       pc_src;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] op;
    logic       reg_we;
    logic [1:0] wb;
  } outs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.WIDTH(W)) bus ();

  multicycle_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [W-1:0] exp_instret = '0;
  logic       exp_illegal = 1'b0;
  logic [6:0] legal_ops [9] = '{OpR, OpI, OpLd, OpSt, OpBr, OpJl, OpJr, OpLu, OpAu};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Control word each state must present, straight from the state table.
  function automatic outs_t ref_outs(input int st, input bit rdy, input bit bt);
    outs_t o;
    o = '0;
    case (st)
      0:  begin o.mem_req = 1; o.b = 2; o.ir_we = rdy; o.pc_we = rdy; end
      1:  begin o.a = 1; o.b = 1; end
      2:  begin o.a = 2; o.b = 0; o.op = 1; end
      3:  begin o.a = 2; o.b = 1; o.op = 1; end
      4:  begin o.a = 2; o.b = 1; end
      5:  begin o.mem_req = 1; o.iord = 1; end
      6:  begin o.mem_req = 1; o.mem_we = 1; o.iord = 1; end
      7:  begin o.reg_we = 1; o.wb = 0; end
      8:  begin o.reg_we = 1; o.wb = 1; end
      9:  begin o.a = 2; o.b = 0; o.op = 2; o.pc_src = 1; o.pc_we = bt; end
      10: begin o.reg_we = 1; o.wb = 2; o.pc_we = 1; o.pc_src = 1; end
      11: begin o.a = 2; o.b = 1; o.pc_we = 1; o.reg_we = 1; o.wb = 2; end
      12: begin o.a = 3; o.b = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  // One clock: drive inputs on the falling edge, check shortly after.
  task automatic run_cycle(input int st, input bit rdy, input bit bt, input logic [6:0] opc);
    outs_t e;
    @(negedge clk);
    reset         = 1'b0;
    bus.opcode    = opc;
    bus.mem_ready = rdy;
    bus.br_taken  = bt;
    #1;
    e = ref_outs(st, rdy, bt);
    chk("state",     32'(bus.state),     32'(st));
    chk("mem_req",   32'(bus.mem_req),   32'(e.mem_req));
    chk("mem_we",    32'(bus.mem_we),    32'(e.mem_we));
    chk("iord",      32'(bus.iord),      32'(e.iord));
    chk("ir_we",     32'(bus.ir_we),     32'(e.ir_we));
    chk("pc_we",     32'(bus.pc_we),     32'(e.pc_we));
    chk("pc_src",    32'(bus.pc_src),    32'(e.pc_src));
    chk("alu_src_a", 32'(bus.alu_src_a), 32'(e.a));
    chk("alu_src_b", 32'(bus.alu_src_b), 32'(e.b));
    chk("alu_op",    32'(bus.alu_op),    32'(e.op));
    chk("reg_we",    32'(bus.reg_we),    32'(e.reg_we));
    chk("wb_sel",    32'(bus.wb_sel),    32'(e.wb));
    chk("illegal",   32'(bus.illegal),   32'(exp_illegal));
    chk("instret",   32'(bus.instret),   32'(exp_instret));
  endtask

  // Entry = state*4 + ready code (0 random, 1 forced low, 2 forced high).
  function automatic int enc(input int st, input int rcode);
    return st * 4 + rcode;
  endfunction

  // One legal instruction: wf fetch waits, wm data waits, bt_mode 0/1 fixed or 2 random.
  task automatic do_instr(input logic [6:0] opc, input int wf, input int wm, input int bt_mode);
    int q[$];
    bit rdy;
    bit bt;
    for (int i = 0; i < wf; i++) q.push_back(enc(0, 1));
    q.push_back(enc(0, 2));
    q.push_back(enc(1, 0));
    case (opc)
      OpR:  begin q.push_back(enc(2, 0)); q.push_back(enc(7, 0)); end
      OpI:  begin q.push_back(enc(3, 0)); q.push_back(enc(7, 0)); end
      OpLu: begin q.push_back(enc(12, 0)); q.push_back(enc(7, 0)); end
      OpAu: q.push_back(enc(7, 0));
      OpLd: begin
        q.push_back(enc(4, 0));
        for (int i = 0; i < wm; i++) q.push_back(enc(5, 1));
        q.push_back(enc(5, 2));
        q.push_back(enc(8, 0));
      end
      OpSt: begin
        q.push_back(enc(4, 0));
        for (int i = 0; i < wm; i++) q.push_back(enc(6, 1));
        q.push_back(enc(6, 2));
      end
      OpBr: q.push_back(enc(9, 0));
      OpJl: q.push_back(enc(10, 0));
      default: q.push_back(enc(11, 0));
    endcase
    foreach (q[i]) begin
      case (q[i] % 4)
        1:       rdy = 1'b0;
        2:       rdy = 1'b1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bt = (bt_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(bt_mode);
      // Opcode is only meaningful after the IR write; feed junk during fetch.
      run_cycle(q[i] / 4, rdy, bt, (q[i] / 4 == 0) ? 7'($urandom) : opc);
    end
    exp_instret = exp_instret + 1'b1;
  endtask

  // Hold reset for n cycles with random inputs; enables must stay low throughout.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset         = 1'b1;
      bus.opcode    = 7'($urandom);
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.br_taken  = 1'($urandom_range(0, 1));
      #1;
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_mem_we",  32'(bus.mem_we),  32'd0);
      chk("rst_ir_we",   32'(bus.ir_we),   32'd0);
      chk("rst_pc_we",   32'(bus.pc_we),   32'd0);
      chk("rst_reg_we",  32'(bus.reg_we),  32'd0);
    end
    exp_instret = '0;
    exp_illegal = 1'b0;
  endtask

  initial begin
    bus.opcode    = '0;
    bus.mem_ready = 1'b0;
    bus.br_taken  = 1'b0;
    do_reset(3);

    // Directed cases.
    do_instr(OpR, 0, 0, 2);
    do_instr(OpLd, 0, 2, 2);
    do_instr(OpBr, 0, 0, 1);
    do_instr(OpBr, 0, 0, 0);
    do_instr(OpJl, 0, 0, 2);
    do_instr(OpJr, 0, 0, 2);
    do_instr(OpSt, 1, 1, 2);
    do_instr(OpLu, 0, 0, 2);
    do_instr(OpAu, 0, 0, 2);
    do_instr(OpI, 2, 0, 2);

    // Random mix, long enough to wrap the counter.
    for (int n = 0; n < 60; n++) begin
      do_instr(legal_ops[$urandom_range(0, 8)], $urandom_range(0, 2), $urandom_range(0, 3), 2);
    end

    // Reset while a store is stalled in MEM_WR.
    run_cycle(0, 1'b1, 1'b0, 7'($urandom));
    run_cycle(1, 1'b0, 1'b0, OpSt);
    run_cycle(4, 1'b1, 1'b0, OpSt);
    run_cycle(6, 1'b0, 1'b0, OpSt);
    run_cycle(6, 1'b0, 1'b0, OpSt);
    do_reset(5);
    do_instr(OpR, 0, 0, 2);
    do_instr(OpSt, 0, 0, 2);

    // Illegal opcode: TRAP is sticky and silent until reset.
    run_cycle(0, 1'b1, 1'b0, 7'($urandom));
    run_cycle(1, 1'b0, 1'b0, 7'b0000000);
    for (int i = 0; i < 20; i++) begin
      run_cycle(15, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 7'($urandom));
      exp_illegal = 1'b1;
    end
    do_reset(2);
    do_instr(OpJl, 0, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
